demux1_2_stream: RTL
====================

# demux1_2_stream

Registered 1-to-2 stream demultiplexer; the counterpart of the team's 2:1 mux, it splits one valid/ready stream onto two output streams. The route is chosen per packet: `in_sel` is sampled on the first beat and held until the `in_last` beat. Each output has a one-entry output register and a saturating completed-packet counter. It sits between a single producer and two independent consumers.

## Interface
Parameters:
- WIDTH, 8, data width in bits.
- CNT_W, 8, width of each packet counter.

Ports (clock and reset first):
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  input beat data.
- in_valid  in  1  input beat is valid.
- in_last  in  1  marks the final beat of a packet.
- in_sel  in  1  destination (0 = out0, 1 = out1); honoured only on the first beat of a packet.
- in_ready  out  1  block can accept the input beat this cycle.
- out0_data, out1_data  out  WIDTH  registered output data.
- out0_valid, out1_valid  out  1  output register holds a beat.
- out0_last, out1_last  out  1  registered copy of `in_last` for that beat.
- out0_ready, out1_ready  in  1  downstream accepts the beat.
- pkt_cnt0, pkt_cnt1  out  CNT_W  completed packets delivered on each output; saturating.

## Operation
State machine:
- IDLE: no packet is open. Destination `dst = in_sel`.
- PKT: a packet is open. Destination `dst = lock_sel`.

Input transfer:
- An input transfer occurs when `in_valid & in_ready`.
- IDLE → PKT on a transfer with `in_last = 0`; `lock_sel` is loaded from `in_sel`.
- IDLE stays IDLE on a transfer with `in_last = 1` (single-beat packet).
- PKT → IDLE on a transfer with `in_last = 1`.
- `in_sel` changes while in PKT are ignored.

Ready and output registers:
- `in_ready = !outN_valid | outN_ready`, where N = `dst`. This is combinational.
- `in_ready` does not depend on `in_valid`.
- On a transfer, output register N loads `{in_data, in_last}` and sets `outN_valid`.
- Output register N clears `outN_valid` when `outN_valid & outN_ready` and no new load occurs in the same cycle.
- Simultaneous drain and load on the same output: the new beat replaces the old one, and valid stays 1.
- The non-selected output register is untouched. It may drain while the input targets the other output.
- Output data and last are stable while `outN_valid & !outN_ready`.

Counters:
- `pkt_cntN` increments on `outN_valid & outN_ready & outN_last`.
- It saturates at 2^CNT_W − 1 and does not wrap.

Reset:
- Synchronous reset forces IDLE, `lock_sel = 0`, `out*_valid = 0`, `out*_data = 0`, `out*_last = 0`, `pkt_cnt* = 0`.
- A packet in flight at reset is discarded with no partial recovery.
- `in_ready` reads 1 after reset (both registers empty).

## Timing
- Latency from input transfer to `outN_valid` is 1 cycle.
- Throughput is 1 beat/cycle per output while `outN_ready` is held high.
- Switching destination between back-to-back packets costs no bubble, provided the new destination register is empty or draining.
- Backpressure reaches `in_ready` in the same cycle as `out*_ready`, through one combinational level.
- Counter update is visible 1 cycle after the accepting edge.
- During reset cycles, input is ignored even if `in_valid` is high.

## Test plan
- **Reset values:** assert rst for 2 cycles with `in_valid = 1` → all outputs 0, `in_ready = 1`, no beat delivered.
- **Single-beat packets, both ready high:** send 0xA5 (sel 0, last 1), then 0x3C (sel 1, last 1) → out0 shows 0xA5 with last 1 at cycle +1, out1 shows 0x3C at cycle +2, `pkt_cnt0 = 1` and `pkt_cnt1 = 1`.
- **Sel lock:** send a 4-beat packet 0x01..0x04 with sel = 1 on beat 1 and sel toggling on beats 2–4 → all 4 beats appear on out1 in order, last only on 0x04, out0_valid never 1.
- **Backpressure:** `out0_ready = 0` with a 3-beat packet to out0 → first beat held stable on out0, `in_ready` drops to 0 after it; raise ready → remaining beats flow at 1/cycle with none lost or duplicated.
- **Independent drain:** out1 holds a beat with `out1_ready = 0` while a packet streams to out0 → out0 runs at full rate and out1 data is unchanged.
- **Counter saturation and mid-packet reset:** with CNT_W = 2, send 5 single-beat packets to out0 → `pkt_cnt0` stops at 3; then reset mid-packet → state IDLE, next beat routed by its own `in_sel`.

Source files
------------

// File: rtl/demux1_2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with per-packet routing
// and a saturating completed-packet counter on each output.
module demux1_2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic {IDLE, PKT} state_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_t           r_state;
  logic             r_lock_sel;
  logic [WIDTH-1:0] r_out0_data, r_out1_data;
  logic             r_out0_valid, r_out1_valid;
  logic             r_out0_last, r_out1_last;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  logic w_dst, w_xfer, w_load0, w_load1, w_drain0, w_drain1;

  // The destination is live from in_sel only on the first beat of a packet.
  assign w_dst    = (r_state == PKT) ? r_lock_sel : in_sel;
  assign in_ready = w_dst ? (!r_out1_valid | out1_ready)
                          : (!r_out0_valid | out0_ready);
  assign w_xfer   = in_valid & in_ready;
  assign w_load0  = w_xfer & !w_dst;
  assign w_load1  = w_xfer &  w_dst;
  assign w_drain0 = r_out0_valid & out0_ready;
  assign w_drain1 = r_out1_valid & out1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_sel <= 1'b0;
    end else if (w_xfer) begin
      case (r_state)
        IDLE: if (!in_last) begin
          r_state    <= PKT;
          r_lock_sel <= in_sel;
        end
        PKT: if (in_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A load wins over a drain so a back-to-back beat replaces the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0_data  <= '0;
      r_out0_last  <= 1'b0;
      r_out0_valid <= 1'b0;
    end else if (w_load0) begin
      r_out0_data  <= in_data;
      r_out0_last  <= in_last;
      r_out0_valid <= 1'b1;
    end else if (w_drain0) begin
      r_out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out1_data  <= '0;
      r_out1_last  <= 1'b0;
      r_out1_valid <= 1'b0;
    end else if (w_load1) begin
      r_out1_data  <= in_data;
      r_out1_last  <= in_last;
      r_out1_valid <= 1'b1;
    end else if (w_drain1) begin
      r_out1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain0 && r_out0_last && r_cnt0 != CntMax) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_drain1 && r_out1_last && r_cnt1 != CntMax) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign out0_data  = r_out0_data;
  assign out0_valid = r_out0_valid;
  assign out0_last  = r_out0_last;
  assign out1_data  = r_out1_data;
  assign out1_valid = r_out1_valid;
  assign out1_last  = r_out1_last;
  assign pkt_cnt0   = r_cnt0;
  assign pkt_cnt1   = r_cnt1;

endmodule
